ps2_kbd_ctrl: RTL and testbench

//   Sequencer between ps2_keyboard FIFO and the display/ASCII path. Pops bytes via the

---
 rtl/ps2_kbd_pkg.sv | 13 +
 rtl/ps2_kbd_ctrl.sv | 120 ++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard sequencer.
package ps2_kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_GAP  = 2'd2
   } ps2_state_e;

   localparam logic [7:0] SC_EXT = 8'hE0;
   localparam logic [7:0] SC_BRK = 8'hF0;

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Pops bytes from the ps2_keyboard FIFO, parses E0/F0 prefixes and tracks the held key,
// distinct-press count and overflow status for the display path.
module ps2_kbd_ctrl
   import ps2_kbd_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int GAP_CYC = 1,
   parameter int TMO_CYC = 65535
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       kb_data,
   input  logic             kb_ready,
   input  logic             kb_overflow,
   output logic             kb_nextdata_n,
   input  logic             ovf_clr,
   output logic             key_held,
   output logic [7:0]       cur_scan,
   output logic             cur_ext,
   output logic [CNT_W-1:0] press_cnt,
   output logic             make_pulse,
   output logic             break_pulse,
   output logic             ovf_sticky
);

   localparam int GW = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);
   localparam int TW = $clog2(TMO_CYC + 1);

   ps2_state_e state, state_nxt;
   logic [GW-1:0] gap_cnt;
   logic [TW-1:0] timer;
   logic          ext_pend, brk_pend;
   logic          take, same_key, gap_done;

   assign take     = (state == ST_IDLE) && kb_ready;
   assign gap_done = (gap_cnt == GW'(GAP_CYC - 1));
   // A byte refers to the held key only if both scan code and extended flag agree
   assign same_key = key_held && (kb_data == cur_scan) && (ext_pend == cur_ext);

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (kb_ready) state_nxt = ST_POP;
         ST_POP:  state_nxt = ST_GAP;
         ST_GAP:  if (gap_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      kb_nextdata_n = (state != ST_POP);
   end

   always_ff @(posedge clock) begin
      if (reset || state != ST_GAP) gap_cnt <= '0;
      else                          gap_cnt <= gap_cnt + GW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_held    <= 1'b0;
         cur_scan    <= 8'h00;
         cur_ext     <= 1'b0;
         press_cnt   <= '0;
         make_pulse  <= 1'b0;
         break_pulse <= 1'b0;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         timer       <= '0;
      end else begin
         make_pulse  <= 1'b0;
         break_pulse <= 1'b0;
         if (take) begin
            timer <= '0;
            if (kb_data == SC_EXT) begin
               ext_pend <= 1'b1;
            end else if (kb_data == SC_BRK) begin
               brk_pend <= 1'b1;
            end else if (brk_pend) begin
               if (same_key) begin
                  key_held    <= 1'b0;
                  break_pulse <= 1'b1;
               end
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
            end else begin
               // Matching make while held is a typematic repeat and leaves state alone
               if (!same_key) begin
                  cur_scan   <= kb_data;
                  cur_ext    <= ext_pend;
                  key_held   <= 1'b1;
                  press_cnt  <= press_cnt + CNT_W'(1);
                  make_pulse <= 1'b1;
               end
               ext_pend <= 1'b0;
            end
         end else if ((ext_pend || brk_pend) && state == ST_IDLE) begin
            if (timer == TW'(TMO_CYC - 1)) begin
               ext_pend <= 1'b0;
               brk_pend <= 1'b0;
               timer    <= '0;
            end else begin
               timer <= timer + TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)            ovf_sticky <= 1'b0;
      else if (kb_overflow) ovf_sticky <= 1'b1;
      else if (ovf_clr)     ovf_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Randomized and directed checks of ps2_kbd_ctrl against a byte-level keyboard model.
module tb_ps2_kbd_ctrl;

   localparam int CNT_W   = 8;
   localparam int GAP_CYC = 2;
   localparam int TMO_CYC = 16;
   localparam int LONG    = 4 * TMO_CYC;

   logic             clock = 1'b0;
   logic             reset;
   logic [7:0]       kb_data;
   logic             kb_ready;
   logic             kb_overflow;
   logic             kb_nextdata_n;
   logic             ovf_clr;
   logic             key_held;
   logic [7:0]       cur_scan;
   logic             cur_ext;
   logic [CNT_W-1:0] press_cnt;
   logic             make_pulse;
   logic             break_pulse;
   logic             ovf_sticky;

   ps2_kbd_ctrl #(.CNT_W(CNT_W), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
      .clock(clock), .reset(reset), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .ovf_clr(ovf_clr),
      .key_held(key_held), .cur_scan(cur_scan), .cur_ext(cur_ext), .press_cnt(press_cnt),
      .make_pulse(make_pulse), .break_pulse(break_pulse), .ovf_sticky(ovf_sticky)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_pass = 0;

   // Reference: what a keyboard listener would conclude from the byte stream
   logic       m_held, m_ext, m_ovf, m_epend, m_bpend, m_mk, m_br;
   logic [7:0] m_scan;
   logic [7:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_held = 0; m_ext = 0; m_ovf = 0; m_epend = 0; m_bpend = 0;
      m_scan = 8'h00; m_cnt = 8'h00; m_mk = 0; m_br = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic refers;
      m_mk = 0; m_br = 0;
      refers = m_held && (b == m_scan) && (m_epend == m_ext);
      if (b == 8'hE0) m_epend = 1;
      else if (b == 8'hF0) m_bpend = 1;
      else begin
         if (m_bpend) begin
            if (refers) begin m_held = 0; m_br = 1; end
         end else if (!refers) begin
            m_scan = b; m_ext = m_epend; m_held = 1; m_cnt = m_cnt + 8'd1; m_mk = 1;
         end
         m_epend = 0; m_bpend = 0;
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".held"}, key_held, m_held);
      chk({tag, ".scan"}, cur_scan, m_scan);
      chk({tag, ".ext"},  cur_ext, m_ext);
      chk({tag, ".cnt"},  press_cnt, m_cnt);
   endtask

   // Present one byte at the FIFO head, wait for the pop, then idle for 'gap' cycles
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got = 0;
      kb_data = b;
      kb_ready = 1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clock);
         if (!kb_nextdata_n) got = 1;
      end
      kb_ready = 0;
      if (!got) begin
         chk("pop_wait", 0, 1);
         return;
      end
      model_byte(b);
      chk("make_pulse", make_pulse, m_mk);
      chk("break_pulse", break_pulse, m_br);
      check_state("pop");
      @(negedge clock);
      chk("strobe_1cyc", kb_nextdata_n, 1);
      chk("pulse_1cyc", {make_pulse, break_pulse}, 0);
      repeat (gap) @(negedge clock);
      if (gap >= LONG) begin m_epend = 0; m_bpend = 0; end
   endtask

   task automatic ovf_step(input logic ov, input logic clr);
      kb_overflow = ov; ovf_clr = clr;
      @(negedge clock);
      kb_overflow = 0; ovf_clr = 0;
      if (ov) m_ovf = 1;
      else if (clr) m_ovf = 0;
      chk("ovf_sticky", ovf_sticky, m_ovf);
   endtask

   task automatic do_reset();
      reset = 1;
      repeat (2) @(negedge clock);
      reset = 0;
      model_reset();
   endtask

   logic [7:0] keys [4];

   initial begin
      keys[0] = 8'h1C; keys[1] = 8'h1B; keys[2] = 8'h75; keys[3] = 8'h23;
      kb_data = 0; kb_ready = 0; kb_overflow = 0; ovf_clr = 0; reset = 0;
      @(negedge clock);
      do_reset();
      chk("rst.strobe", kb_nextdata_n, 1);
      chk("rst.pulses", {make_pulse, break_pulse}, 0);
      chk("rst.ovf", ovf_sticky, 0);
      check_state("rst");

      // Single make, then release
      send_byte(8'h1C, 2);
      send_byte(8'hF0, 0); send_byte(8'h1C, 2);
      // Typematic repeats count once
      send_byte(8'h1B, 0); send_byte(8'h1B, 0); send_byte(8'h1B, 0);
      send_byte(8'hF0, 0); send_byte(8'h1B, 2);
      // Extended key not released by a non-extended break
      send_byte(8'hE0, 0); send_byte(8'h75, 1);
      send_byte(8'hF0, 0); send_byte(8'h75, 1);
      chk("ext.held", key_held, 1);
      // Orphan break prefix times out; next byte is a make
      send_byte(8'hF0, LONG);
      send_byte(8'h1C, 1);
      chk("tmo.make", key_held, 1);

      // Reset during the pop cycle drops the strobe on the next edge
      kb_data = 8'h23; kb_ready = 1;
      for (int i = 0; i < 20 && kb_nextdata_n; i++) @(negedge clock);
      reset = 1; kb_ready = 0;
      @(negedge clock);
      chk("rst_midpop.strobe", kb_nextdata_n, 1);
      reset = 0;
      model_reset();
      @(negedge clock);
      check_state("rst_midpop");

      // Counter wrap after 256 distinct presses
      for (int i = 0; i < 255; i++) send_byte((i % 2) ? 8'h1B : 8'h1C, 0);
      chk("cnt.max", press_cnt, 8'hFF);
      send_byte(8'h23, 0);
      chk("cnt.wrap", press_cnt, 8'h00);

      // Overflow set wins over clear
      ovf_step(1, 1);
      ovf_step(0, 1);
      ovf_step(1, 0);
      ovf_step(0, 0);

      for (int it = 0; it < 300; it++) begin
         int r;
         logic [7:0] k;
         logic e;
         r = $urandom_range(0, 10);
         k = keys[$urandom_range(0, 3)];
         e = 1'($urandom_range(0, 1));
         if (r <= 4) begin
            if (e) send_byte(8'hE0, $urandom_range(0, 3));
            send_byte(k, $urandom_range(0, 3));
         end else if (r <= 7) begin
            if (m_held && r != 7) begin k = m_scan; e = m_ext; end
            if (e) send_byte(8'hE0, $urandom_range(0, 3));
            send_byte(8'hF0, $urandom_range(0, 3));
            send_byte(k, $urandom_range(0, 3));
         end else if (r == 8) begin
            send_byte(e ? 8'hE0 : 8'hF0, LONG);
         end else if (r == 9) begin
            send_byte(e ? 8'hE0 : 8'hF0, $urandom_range(0, 3));
         end else begin
            ovf_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
      end
      check_state("final");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
